// File: rtl/sha3_host_master.sv
// rtl/sha3_host_master.sv - memory-fed streaming driver for the SHA3 wrapper; optional watchdog via SHA3_HOST_TIMEOUT_EN
module sha3_host_master #(
  parameter int ADDR_W       = 8,
  parameter int LEN_W        = 8,
  parameter int DIGEST_WORDS = 4,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [LEN_W-1:0]           msg_len,
  output logic                       busy,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [63:0]                rd_data,
  output logic                       in_valid,
  output logic [63:0]                in_data,
  output logic                       in_done,
  input  logic                       in_ready,
  input  logic                       out_valid,
  input  logic [63:0]                out_data,
  output logic                       out_ready,
  output logic [64*DIGEST_WORDS-1:0] digest,
  output logic                       digest_valid,
  output logic                       err
);

  localparam int DIG_W = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGEST_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_SEND, S_COLLECT, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  word_idx;
  logic [63:0]       word_reg;
  logic [DIG_W-1:0]  dig_idx;
  logic              in_hs, out_hs, last_word, accept, timeout;

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_word = (word_idx == len_reg - LEN_W'(1));
  assign accept    = (state == S_IDLE) && start && (msg_len != '0);

`ifdef SHA3_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;

  assign timeout = (((state == S_SEND) && !in_hs) || ((state == S_COLLECT) && !out_hs))
                   && (tcnt == TW'(TIMEOUT_CYC - 1));

  // Stall watchdog: counts idle cycles in SEND/COLLECT, restarts on any handshake or state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if ((state_nx != state) || in_hs || out_hs) begin
      tcnt <= '0;
    end else if ((state == S_SEND) || (state == S_COLLECT)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Sticky error, cleared only by reset or the next accepted command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs; every output is derived from the registered state
  always_comb begin
    state_nx     = state;
    busy         = (state != S_IDLE);
    rd_en        = 1'b0;
    rd_addr      = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_done      = 1'b0;
    out_ready    = 1'b0;
    digest_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = S_FETCH;
      end
      S_FETCH: begin
        rd_en    = 1'b1;
        rd_addr  = base_reg + ADDR_W'(word_idx);
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        state_nx = S_SEND;
      end
      S_SEND: begin
        in_valid = 1'b1;
        in_data  = word_reg;
        in_done  = last_word;
        if (timeout)    state_nx = S_IDLE;
        else if (in_hs) state_nx = last_word ? S_COLLECT : S_FETCH;
      end
      S_COLLECT: begin
        out_ready = 1'b1;
        if (timeout)                           state_nx = S_IDLE;
        else if (out_hs && dig_idx == DIG_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        digest_valid = 1'b1;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command latch, word fetch pipeline and digest assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg <= '0;
      len_reg  <= '0;
      word_idx <= '0;
      word_reg <= '0;
      dig_idx  <= '0;
      digest   <= '0;
    end else begin
      if (accept) begin
        base_reg <= base_addr;
        len_reg  <= msg_len;
        word_idx <= '0;
      end
      if (state == S_WAIT) word_reg <= rd_data;
      if ((state == S_SEND) && in_hs) begin
        if (last_word) dig_idx  <= '0;
        else           word_idx <= word_idx + LEN_W'(1);
      end
      if ((state == S_COLLECT) && out_hs) begin
        for (int i = 0; i < DIGEST_WORDS; i++) begin
          if (dig_idx == DIG_W'(i)) digest[(DIGEST_WORDS-1-i)*64 +: 64] <= out_data;
        end
        dig_idx <= dig_idx + DIG_W'(1);
      end
    end
  end

endmodule
